video_bus_ctrl: RTL

VIDEO_BUS_CTRL -- requirements
Module: video_bus_ctrl

---
 rtl/video_bus_ctrl.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/video_bus_ctrl.sv
// video_bus_ctrl
//   ISA-side register block for a CGA/MDA-style video adapter.
//   - I/O write decoding for the control, color, mode-address and
//     palette-data ports.
//   - Combinational status read with a bus direction flag.
//   - Blink generator.
//   - Optional ISA wait-state generator for framebuffer accesses.
//
// Configuration macro:
//   VIDEO_BUS_WAIT_EN
//     Defined:   builds the wait-state FSM.
//     Undefined: bus_rdy is tied high and no FSM state flops exist.
//
// Ports:
//   clk, reset             pixel clock, synchronous active-high reset
//   bus_a, bus_d           ISA address (15 bits) and write data (8 bits)
//   bus_ior_l, bus_iow_l   active-low I/O read / write strobes
//   bus_memr_l, bus_memw_l active-low memory read / write strobes
//   bus_aen                DMA address enable; I/O decodes only while it is low
//   bus_out, bus_dir       read data, and a flag that is high while a read is driven
//   bus_rdy                ISA ready (low inserts wait states)
//   clk_seq                current character-sequencer slot
//   vsync_l                active-low vertical sync, reported in status
//   display_enable         high during active video, reported in status
//   freeze                 halts the blink generator
//   mem_cs                 framebuffer address decode
//   control_reg            mode control register
//   color_reg              color select register
//   border_col             border color
//   pal_index, pal_data    palette write port
//   pal_we                 one-cycle palette write pulse
//   blink                  blink phase output

module video_bus_ctrl #(
  parameter logic [15:0] IO_BASE_ADDR = 16'h3d0,
  parameter int          PAL_DEPTH    = 16,
  parameter int          PAL_WIDTH    = 4,
  parameter logic [23:0] BLINK_MAX    = 24'd0,
  parameter logic [4:0]  WAIT_SLOT_A  = 5'd17,
  parameter logic [4:0]  WAIT_SLOT_B  = 5'd20
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [14:0]                  bus_a,
  input  logic [7:0]                   bus_d,
  input  logic                         bus_ior_l,
  input  logic                         bus_iow_l,
  input  logic                         bus_memr_l,
  input  logic                         bus_memw_l,
  input  logic                         bus_aen,
  output logic [7:0]                   bus_out,
  output logic                         bus_dir,
  output logic                         bus_rdy,
  input  logic [4:0]                   clk_seq,
  input  logic                         vsync_l,
  input  logic                         display_enable,
  input  logic                         freeze,
  input  logic                         mem_cs,
  output logic [7:0]                   control_reg,
  output logic [7:0]                   color_reg,
  output logic [3:0]                   border_col,
  output logic [$clog2(PAL_DEPTH)-1:0] pal_index,
  output logic [PAL_WIDTH-1:0]         pal_data,
  output logic                         pal_we,
  output logic                         blink
);

  localparam int          IDX_W     = $clog2(PAL_DEPTH);
  localparam logic [14:0] BASE      = IO_BASE_ADDR[14:0];
  localparam logic [14:0] ADDR_CTRL = BASE + 15'h8;
  localparam logic [14:0] ADDR_COLR = BASE + 15'h9;
  localparam logic [14:0] ADDR_STAT = BASE + 15'hA;
  localparam logic [14:0] ADDR_PAL  = BASE + 15'hE;
  // CRTC registers at BASE+0..7 are decoded and muxed outside this block.

  // ---------------------------------------------------------------
  // Strobe synchronisation and decode
  // ---------------------------------------------------------------
  logic iow_q;
  logic ior_q;
  logic wr_stb;
  logic sel_ctrl;
  logic sel_colr;
  logic sel_stat;
  logic sel_pal;

  // The write fires on the clock edge where the synced iow falls
  // (synced copy still high, bus already low). A strobe held low
  // therefore writes once.
  assign wr_stb   = iow_q & ~bus_iow_l;
  assign sel_ctrl = ~bus_aen & (bus_a == ADDR_CTRL);
  assign sel_colr = ~bus_aen & (bus_a == ADDR_COLR);
  assign sel_stat = ~bus_aen & (bus_a == ADDR_STAT);
  assign sel_pal  = ~bus_aen & (bus_a == ADDR_PAL);

  // Reads are served combinationally. The synced read strobe is kept
  // only so that both strobes share the same reset behaviour.
  logic unused_ior;
  assign unused_ior = ior_q;

  // ---------------------------------------------------------------
  // Status read
  // ---------------------------------------------------------------
  always_comb begin
    bus_out = 8'h00;
    bus_dir = 1'b0;
    if (sel_stat && !bus_ior_l) begin
      bus_out = {4'b1111, vsync_l, 2'b10, ~display_enable};
      bus_dir = 1'b1;
    end
  end

  // ---------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------
  logic [7:0]           control_q, control_d;
  logic [7:0]           color_q,   color_d;
  logic [7:0]           addr_q,    addr_d;
  logic [3:0]           border_q,  border_d;
  logic [IDX_W-1:0]     pal_index_q, pal_index_d;
  logic [PAL_WIDTH-1:0] pal_data_q,  pal_data_d;
  logic                 pal_we_q,    pal_we_d;
  logic [IDX_W-1:0]     idx_inc;

  // Auto-increment wraps at the palette depth, not at 16.
  assign idx_inc = addr_q[IDX_W-1:0] + IDX_W'(1);

  always_comb begin
    control_d   = control_q;
    color_d     = color_q;
    addr_d      = addr_q;
    border_d    = border_q;
    pal_index_d = pal_index_q;
    pal_data_d  = pal_data_q;
    pal_we_d    = 1'b0;
    if (wr_stb) begin
      if (sel_ctrl) control_d = bus_d;
      if (sel_colr) color_d   = bus_d;
      if (sel_stat) addr_d    = bus_d;
      if (sel_pal) begin
        if (addr_q[7:4] == 4'h1) begin
          pal_index_d = addr_q[IDX_W-1:0];
          pal_data_d  = bus_d[PAL_WIDTH-1:0];
          pal_we_d    = 1'b1;
          addr_d      = {4'h1, 4'(idx_inc)};
        end else if (addr_q == 8'h02) begin
          border_d = bus_d[3:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      iow_q       <= 1'b1;
      ior_q       <= 1'b1;
      control_q   <= 8'b0010_1001;
      color_q     <= 8'h00;
      addr_q      <= 8'h00;
      border_q    <= 4'h0;
      pal_index_q <= '0;
      pal_data_q  <= '0;
      pal_we_q    <= 1'b0;
    end else begin
      iow_q       <= bus_iow_l;
      ior_q       <= bus_ior_l;
      control_q   <= control_d;
      color_q     <= color_d;
      addr_q      <= addr_d;
      border_q    <= border_d;
      pal_index_q <= pal_index_d;
      pal_data_q  <= pal_data_d;
      pal_we_q    <= pal_we_d;
    end
  end

  assign control_reg = control_q;
  assign color_reg   = color_q;
  assign border_col  = border_q;
  assign pal_index   = pal_index_q;
  assign pal_data    = pal_data_q;
  assign pal_we      = pal_we_q;

  // ---------------------------------------------------------------
  // Blink generator: toggles once every BLINK_MAX+1 unfrozen cycles
  // ---------------------------------------------------------------
  logic [23:0] blink_cnt_q, blink_cnt_d;
  logic        blink_q,     blink_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    if (!freeze) begin
      if (blink_cnt_q == BLINK_MAX) begin
        blink_cnt_d = 24'd0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 24'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_q <= 24'd0;
      blink_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign blink = blink_q;

  // ---------------------------------------------------------------
  // Wait-state generator for framebuffer accesses
  // ---------------------------------------------------------------
`ifdef VIDEO_BUS_WAIT_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT_A = 2'd1,
    ST_WAIT_B = 2'd2,
    ST_READY  = 2'd3
  } wait_state_t;

  wait_state_t state_q, state_d;
  logic        mem_access;

  // Only memory strobes qualified by mem_cs start a wait; I/O cycles
  // never touch this machine.
  assign mem_access = mem_cs & (~bus_memr_l | ~bus_memw_l);

  always_comb begin
    state_d = state_q;
    bus_rdy = 1'b1;
    case (state_q)
      ST_IDLE: begin
        // Pull ready low already in the cycle the access is seen, so the
        // CPU cannot complete before the first wait state. Held off during
        // reset so ready is high while the machine is being cleared.
        if (mem_access && !reset) begin
          state_d = ST_WAIT_A;
          bus_rdy = 1'b0;
        end
      end
      ST_WAIT_A: begin
        bus_rdy = 1'b0;
        if (!mem_access)                state_d = ST_IDLE;
        else if (clk_seq == WAIT_SLOT_A) state_d = ST_WAIT_B;
      end
      ST_WAIT_B: begin
        bus_rdy = 1'b0;
        if (!mem_access)                state_d = ST_IDLE;
        else if (clk_seq == WAIT_SLOT_B) state_d = ST_READY;
      end
      ST_READY: begin
        if (!mem_access) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end
`else
  assign bus_rdy = 1'b1;

  logic unused_wait;
  assign unused_wait = ^{clk_seq, bus_memr_l, bus_memw_l, mem_cs};
`endif

endmodule
